// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the RV32I datapath.
// Drives IR/regfile/dmem/PC strobes and faults on illegal opcodes or data-memory timeout.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 EQ,
  input  logic                 mem_ack,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCSrc,
  output logic                 JumpSrc,
  output logic                 JRetSrc,
  output logic                 RegWrite,
  output logic                 ResultSrc,
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] instret,
  output logic                 fault,
  output logic [2:0]           state
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI
  } class_t;

  state_t              r_state, w_next;
  class_t              r_class, w_dec_class;
  logic [2:0]          r_funct3;
  logic [WW-1:0]       r_wait;
  logic [CNT_WIDTH-1:0] r_instret;
  logic                w_taken;

  always_comb begin
    w_dec_class = C_NONE;
    case (opcode)
      7'b0110011: w_dec_class = C_R;
      7'b0010011: w_dec_class = C_I;
      7'b0000011: w_dec_class = C_LOAD;
      7'b0100011: w_dec_class = C_STORE;
      7'b1100011: w_dec_class = C_BRANCH;
      7'b1101111: w_dec_class = C_JAL;
      7'b1100111: w_dec_class = C_JALR;
      7'b0110111: w_dec_class = C_LUI;
      default:    w_dec_class = C_NONE;
    endcase
  end

  assign w_taken = ((r_funct3 == 3'b000) && EQ) || ((r_funct3 == 3'b001) && !EQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_class   <= C_NONE;
      r_funct3  <= 3'b000;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_class  <= w_dec_class;
        r_funct3 <= funct3;
      end
      // Counter sits at zero outside MEMORY, so every MEMORY visit starts clean.
      if (r_state != S_MEMORY)
        r_wait <= '0;
      else if (!mem_ack)
        r_wait <= r_wait + 1'b1;
      if (retire)
        r_instret <= r_instret + 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    JumpSrc   = 1'b0;
    JRetSrc   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    retire    = 1'b0;
    fault     = 1'b0;
    case (r_state)
      S_FETCH: begin
        // rst_n gate keeps IRWrite quiet while reset holds the state in FETCH.
        IRWrite = instr_valid && rst_n;
        if (instr_valid) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = (w_dec_class == C_NONE) ? S_FAULT : S_EXECUTE;
      end
      S_EXECUTE: begin
        case (r_class)
          C_BRANCH: begin
            PCWrite = 1'b1;
            PCSrc   = w_taken;
            retire  = 1'b1;
            w_next  = S_FETCH;
          end
          C_LOAD, C_STORE: w_next = S_MEMORY;
          default:         w_next = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        MemReq   = 1'b1;
        MemWrite = (r_class == C_STORE);
        if (mem_ack) begin
          if (r_class == C_STORE) begin
            PCWrite = 1'b1;
            retire  = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next = S_WRITEBACK;
          end
        end else if (r_wait == LAST_WAIT) begin
          w_next = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
        retire    = 1'b1;
        ResultSrc = (r_class == C_LOAD);
        JumpSrc   = (r_class == C_JAL) || (r_class == C_JALR);
        PCSrc     = JumpSrc;
        JRetSrc   = (r_class == C_JALR);
        w_next    = S_FETCH;
      end
      S_FAULT: begin
        fault  = 1'b1;
        w_next = S_FAULT;
      end
      default: w_next = S_FAULT;
    endcase
  end

  assign instret = r_instret;
  assign state   = r_state;

endmodule
